// File: rtl/types_pkg.sv
// Shared types and constants for the scratchpad command sequencer.
// SPAD_SEQ_TIMEOUT is used only when the design is built with SPAD_SEQ_TIMEOUT_EN.
package types_pkg;

    localparam int MAT_S_W          = 2;
    localparam int ROW_S_W          = 3;
    localparam int WORD_W           = 16;
    localparam int NUM_ROWS         = 2 ** ROW_S_W;
    localparam int SPAD_SEQ_TIMEOUT = 16;
    localparam int TMO_W            = $clog2(SPAD_SEQ_TIMEOUT + 1);
    localparam int WDATA_W          = 2 + MAT_S_W + ROW_S_W + WORD_W;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_GEMM  = 2'b11
    } spad_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    // Clamp a requested row count to the number of scratchpad rows.
    function automatic logic [ROW_S_W:0] sat_rows(input logic [ROW_S_W:0] rows);
        logic [ROW_S_W:0] lim;
        lim = (ROW_S_W + 1)'(NUM_ROWS);
        if (rows > lim) begin
            sat_rows = lim;
        end else begin
            sat_rows = rows;
        end
    endfunction

endpackage

// File: rtl/spad_cmd_sequencer.sv
// Scratchpad command sequencer: accepts LOAD/STORE/GEMM matrix commands,
// expands them into per-row instruction FIFO writes and waits for completion.
// Optional build macro: SPAD_SEQ_TIMEOUT_EN adds a WAIT timeout that ends the
// command with err=1 after SPAD_SEQ_TIMEOUT cycles without completion.
module spad_cmd_sequencer
    import types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [MAT_S_W-1:0]    cmd_mat,
    input  logic [WORD_W-1:0]     cmd_base_addr,
    input  logic [WORD_W-1:0]     cmd_stride,
    input  logic [ROW_S_W:0]      cmd_rows,
    output logic                  instrFIFO_WEN,
    output logic [WDATA_W-1:0]    instrFIFO_wdata,
    input  logic                  instrFIFO_full,
    input  logic                  load_complete,
    input  logic                  gemm_complete,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    seq_state_t           state_r;
    seq_state_t           state_s;
    spad_op_t             op_r;
    logic [MAT_S_W-1:0]   mat_r;
    logic [ROW_S_W-1:0]   row_r;
    logic [WORD_W-1:0]    addr_r;
    logic [WORD_W-1:0]    stride_r;
    logic [ROW_S_W:0]     rows_r;
    logic [ROW_S_W:0]     lcnt_r;
    logic [ROW_S_W:0]     lcnt_s;
    logic                 gemm_seen_r;
    logic                 gemm_seen_s;
    logic                 ready_r;
    logic                 done_r;
    logic                 accept_s;
    logic                 active_s;
    logic                 last_s;
    logic                 wen_s;
    logic                 wait_cplt_s;
    logic                 tmo_s;

    assign accept_s = cmd_valid && ready_r && (state_r == SEQ_IDLE);
    assign active_s = (state_r == SEQ_ISSUE) || (state_r == SEQ_WAIT);
    // GEMM always issues a single entry; other ops stop at the latched row count.
    assign last_s   = (op_r == OP_GEMM) ||
                      ({1'b0, row_r} == (rows_r - (ROW_S_W + 1)'(1)));

    // Completion tracking: only pulses belonging to the active op are counted.
    always_comb begin
        lcnt_s      = lcnt_r;
        gemm_seen_s = gemm_seen_r;
        if (active_s && (op_r == OP_LOAD) && load_complete && (lcnt_r != rows_r)) begin
            lcnt_s = lcnt_r + (ROW_S_W + 1)'(1);
        end else begin
            lcnt_s = lcnt_r;
        end
        if (active_s && (op_r == OP_GEMM) && gemm_complete) begin
            gemm_seen_s = 1'b1;
        end else begin
            gemm_seen_s = gemm_seen_r;
        end
    end

    assign wait_cplt_s = (op_r == OP_GEMM) ? gemm_seen_s : (lcnt_s == rows_r);

`ifdef SPAD_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    assign tmo_s = (state_r == SEQ_WAIT) &&
                   (tmo_cnt_r == TMO_W'(SPAD_SEQ_TIMEOUT - 1));

    // WAIT cycle counter and error flag raised alongside a timeout-forced done.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            if (state_r == SEQ_WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            err_r <= (state_r == SEQ_WAIT) && !wait_cplt_s && tmo_s;
        end
    end

    assign err = err_r;
`else
    assign tmo_s = 1'b0;
    assign err   = 1'b0;
`endif

    // Next-state and FIFO write strobe; the write stalls combinationally on full.
    always_comb begin
        state_s = state_r;
        wen_s   = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (accept_s) begin
                    if ((cmd_rows == {(ROW_S_W + 1){1'b0}}) || (cmd_op == OP_NONE)) begin
                        state_s = SEQ_DONE;
                    end else begin
                        state_s = SEQ_ISSUE;
                    end
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                if (!instrFIFO_full) begin
                    wen_s = 1'b1;
                    if (last_s) begin
                        if (op_r == OP_STORE) begin
                            state_s = SEQ_DONE;
                        end else begin
                            state_s = SEQ_WAIT;
                        end
                    end else begin
                        state_s = SEQ_ISSUE;
                    end
                end else begin
                    wen_s   = 1'b0;
                    state_s = SEQ_ISSUE;
                end
            end
            SEQ_WAIT: begin
                if (wait_cplt_s) begin
                    state_s = SEQ_DONE;
                end else if (tmo_s) begin
                    state_s = SEQ_DONE;
                end else begin
                    state_s = SEQ_WAIT;
                end
            end
            SEQ_DONE: begin
                state_s = SEQ_IDLE;
            end
            default: begin
                state_s = SEQ_IDLE;
            end
        endcase
    end

    // State register plus registered ready/done, held low while in reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= SEQ_IDLE;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == SEQ_IDLE);
            done_r  <= (state_s == SEQ_DONE);
        end
    end

    // Command latch and inline row/address generator.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_r        <= OP_NONE;
            mat_r       <= {MAT_S_W{1'b0}};
            row_r       <= {ROW_S_W{1'b0}};
            addr_r      <= {WORD_W{1'b0}};
            stride_r    <= {WORD_W{1'b0}};
            rows_r      <= {(ROW_S_W + 1){1'b0}};
            lcnt_r      <= {(ROW_S_W + 1){1'b0}};
            gemm_seen_r <= 1'b0;
        end else if (accept_s) begin
            op_r        <= spad_op_t'(cmd_op);
            mat_r       <= cmd_mat;
            row_r       <= {ROW_S_W{1'b0}};
            addr_r      <= cmd_base_addr;
            stride_r    <= cmd_stride;
            rows_r      <= sat_rows(cmd_rows);
            lcnt_r      <= {(ROW_S_W + 1){1'b0}};
            gemm_seen_r <= 1'b0;
        end else begin
            // The final entry stays on wdata; only intermediate writes advance.
            if (wen_s && !last_s) begin
                row_r  <= row_r + ROW_S_W'(1);
                addr_r <= addr_r + stride_r;
            end
            lcnt_r      <= lcnt_s;
            gemm_seen_r <= gemm_seen_s;
        end
    end

    assign cmd_ready       = ready_r;
    assign instrFIFO_WEN   = wen_s;
    assign instrFIFO_wdata = {op_r, mat_r, row_r, addr_r};
    assign busy            = (state_r != SEQ_IDLE);
    assign done            = done_r;

endmodule
